// File: rtl/eclair_exec_core.sv
// rtl/eclair_exec_core.sv - ECLair execution core: 74181-style ALU, loadable up-counter, 3-to-8 active-low decoder; ECLAIR_ALU_FLAGS_EN enables c_out/zero
module eclair_exec_core #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alu_mode,
  input  logic [3:0]       alu_op,
  input  logic             c_in,
  input  logic [15:0]      x,
  input  logic [15:0]      y,
  output logic [15:0]      z,
  output logic             c_out,
  output logic             zero,
  input  logic             load,
  input  logic             inc,
  input  logic [WIDTH-1:0] preset,
  output logic [WIDTH-1:0] out,
  input  logic [2:0]       dmx_sel,
  input  logic             dmx_en,
  output logic [7:0]       dmx_out
);

`ifdef ECLAIR_ALU_FLAGS_EN
  // the extra sum bit is the carry out of bit 15
  localparam int SW = 17;
`else
  // flags build-out: the adder stays 16 bits wide, no carry chain extension
  localparam int SW = 16;
`endif

  logic [15:0]   arith_p;
  logic [15:0]   arith_q;
  logic [15:0]   logic_z;
  logic [SW-1:0] sum;

  // arithmetic mode: pick the two addend terms for S, then add them with c_in
  always_comb begin
    arith_p = 16'h0000;
    arith_q = 16'h0000;
    case (alu_op)
      4'h0: begin arith_p = x;        arith_q = 16'h0000; end
      4'h1: begin arith_p = x | y;    arith_q = 16'h0000; end
      4'h2: begin arith_p = x | ~y;   arith_q = 16'h0000; end
      4'h3: begin arith_p = 16'hFFFF; arith_q = 16'h0000; end
      4'h4: begin arith_p = x;        arith_q = x & ~y;   end
      4'h5: begin arith_p = x | y;    arith_q = x & ~y;   end
      4'h6: begin arith_p = x;        arith_q = ~y;       end
      4'h7: begin arith_p = x & ~y;   arith_q = 16'hFFFF; end
      4'h8: begin arith_p = x;        arith_q = x & y;    end
      4'h9: begin arith_p = x;        arith_q = y;        end
      4'hA: begin arith_p = x | ~y;   arith_q = x & y;    end
      4'hB: begin arith_p = x & y;    arith_q = 16'hFFFF; end
      4'hC: begin arith_p = x;        arith_q = x;        end
      4'hD: begin arith_p = x | y;    arith_q = x;        end
      4'hE: begin arith_p = x | ~y;   arith_q = x;        end
      4'hF: begin arith_p = x;        arith_q = 16'hFFFF; end
      default: begin arith_p = 16'h0000; arith_q = 16'h0000; end
    endcase
    sum = SW'(arith_p) + SW'(arith_q) + SW'(c_in);
  end

  // logic mode: bitwise function table, carry input plays no part
  always_comb begin
    logic_z = 16'h0000;
    case (alu_op)
      4'h0: logic_z = ~x;
      4'h1: logic_z = ~(x | y);
      4'h2: logic_z = ~x & y;
      4'h3: logic_z = 16'h0000;
      4'h4: logic_z = ~(x & y);
      4'h5: logic_z = ~y;
      4'h6: logic_z = x ^ y;
      4'h7: logic_z = x & ~y;
      4'h8: logic_z = ~x | y;
      4'h9: logic_z = ~(x ^ y);
      4'hA: logic_z = y;
      4'hB: logic_z = x & y;
      4'hC: logic_z = 16'hFFFF;
      4'hD: logic_z = x | ~y;
      4'hE: logic_z = x | y;
      4'hF: logic_z = x;
      default: logic_z = 16'h0000;
    endcase
  end

  // result mux and status flags
  always_comb begin
    z = alu_mode ? logic_z : sum[15:0];
`ifdef ECLAIR_ALU_FLAGS_EN
    c_out = alu_mode ? 1'b0 : sum[16];
    zero  = (z == 16'h0000);
`else
    c_out = 1'b0;
    zero  = 1'b0;
`endif
  end

  // program counter / sequencer: reset beats load beats inc beats hold
  always_ff @(posedge clk) begin
    if (reset) begin
      out <= '0;
    end else if (load) begin
      out <= preset;
    end else if (inc) begin
      out <= out + WIDTH'(1);
    end
  end

  // register load strobe decoder, one active-low line when enabled
  always_comb begin
    dmx_out = 8'hFF;
    if (dmx_en) begin
      dmx_out = ~(8'h01 << dmx_sel);
    end
  end

endmodule

// File: tb/tb_eclair_exec_core.sv
// tb/tb_eclair_exec_core.sv - self-checking bench for eclair_exec_core with a behavioural model
module tb_eclair_exec_core;
  logic        clk = 1'b0;
  logic        reset, alu_mode, c_in, load, inc, dmx_en;
  logic [3:0]  alu_op;
  logic [15:0] x, y, z, preset, out;
  logic        c_out, zero;
  logic [2:0]  dmx_sel;
  logic [7:0]  dmx_out;

  int total = 0;
  int bad = 0;
  logic [15:0] mcnt;

  eclair_exec_core #(.WIDTH(16)) dut (
    .clk(clk), .reset(reset), .alu_mode(alu_mode), .alu_op(alu_op), .c_in(c_in),
    .x(x), .y(y), .z(z), .c_out(c_out), .zero(zero),
    .load(load), .inc(inc), .preset(preset), .out(out),
    .dmx_sel(dmx_sel), .dmx_en(dmx_en), .dmx_out(dmx_out)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // arithmetic result in plain unsigned integer arithmetic, 17 significant bits
  function automatic logic [16:0] ref_arith(logic [3:0] s, logic [15:0] a, logic [15:0] b, logic ci);
    int unsigned ua, ub, nb, r;
    ua = a; ub = b; nb = 32'hFFFF - ub;
    case (s)
      4'h0: r = ua;
      4'h1: r = ua | ub;
      4'h2: r = ua | nb;
      4'h3: r = 32'hFFFF;
      4'h4: r = ua + (ua & nb);
      4'h5: r = (ua | ub) + (ua & nb);
      4'h6: r = ua + nb;
      4'h7: r = (ua & nb) + 32'hFFFF;
      4'h8: r = ua + (ua & ub);
      4'h9: r = ua + ub;
      4'hA: r = (ua | nb) + (ua & ub);
      4'hB: r = (ua & ub) + 32'hFFFF;
      4'hC: r = ua * 2;
      4'hD: r = (ua | ub) + ua;
      4'hE: r = (ua | nb) + ua;
      default: r = ua + 32'hFFFF;
    endcase
    r = r + ci;
    return r[16:0];
  endfunction

  function automatic logic [15:0] ref_logic(logic [3:0] s, logic [15:0] a, logic [15:0] b);
    case (s)
      4'h0: return ~a;
      4'h1: return ~(a | b);
      4'h2: return ~a & b;
      4'h3: return 16'h0000;
      4'h4: return ~(a & b);
      4'h5: return ~b;
      4'h6: return a ^ b;
      4'h7: return a & ~b;
      4'h8: return ~a | b;
      4'h9: return ~(a ^ b);
      4'hA: return b;
      4'hB: return a & b;
      4'hC: return 16'hFFFF;
      4'hD: return a | ~b;
      4'hE: return a | b;
      default: return a;
    endcase
  endfunction

  // compare combinational outputs against the model for the current inputs
  task automatic check_comb();
    logic [16:0] ar;
    logic [15:0] ez;
    logic        ec, ezr;
    logic [7:0]  ed;
    ar = ref_arith(alu_op, x, y, c_in);
    ez = alu_mode ? ref_logic(alu_op, x, y) : ar[15:0];
`ifdef ECLAIR_ALU_FLAGS_EN
    ec  = alu_mode ? 1'b0 : ar[16];
    ezr = (ez == 16'h0000);
`else
    ec  = 1'b0;
    ezr = 1'b0;
`endif
    ed = 8'hFF;
    if (dmx_en) ed[dmx_sel] = 1'b0;
    chk("z", 32'(z), 32'(ez));
    chk("c_out", 32'(c_out), 32'(ec));
    chk("zero", 32'(zero), 32'(ezr));
    chk("dmx_out", 32'(dmx_out), 32'(ed));
  endtask

  // one cycle: check comb outputs, advance model counter at the edge, check counter
  task automatic step();
    #1 check_comb();
    @(posedge clk);
    if (reset) mcnt = 16'h0000;
    else if (load) mcnt = preset;
    else if (inc) mcnt = mcnt + 16'h0001;
    @(negedge clk);
    chk("out", 32'(out), 32'(mcnt));
  endtask

  initial begin
    reset = 1'b1; alu_mode = 1'b0; alu_op = 4'h0; c_in = 1'b0; x = 16'h0; y = 16'h0;
    load = 1'b1; inc = 1'b0; preset = 16'h1234; dmx_sel = 3'd0; dmx_en = 1'b0;
    @(negedge clk);
    step();
    chk("reset_out", 32'(out), 32'h0000);

    reset = 1'b0; load = 1'b1; preset = 16'hFFFE;
    step();
    load = 1'b0; inc = 1'b1;
    step(); chk("inc1", 32'(out), 32'hFFFF);
    step(); chk("inc_wrap", 32'(out), 32'h0000);
    step(); chk("inc3", 32'(out), 32'h0001);
    load = 1'b1; preset = 16'h00AA;
    step(); chk("load_over_inc", 32'(out), 32'h00AA);
    load = 1'b0;
    step();
    reset = 1'b1; load = 1'b1; preset = 16'h5555;
    step(); chk("mid_reset", 32'(out), 32'h0000);
    reset = 1'b0; load = 1'b0;
    step(); chk("first_after_reset", 32'(out), 32'h0001);
    inc = 1'b0;

    alu_mode = 1'b0; alu_op = 4'h9; c_in = 1'b0; x = 16'hFFFF; y = 16'h0001;
    #1;
    chk("add_z", 32'(z), 32'h0000);
`ifdef ECLAIR_ALU_FLAGS_EN
    chk("add_cout", 32'(c_out), 32'h1);
    chk("add_zero", 32'(zero), 32'h1);
`else
    chk("add_cout_off", 32'(c_out), 32'h0);
    chk("add_zero_off", 32'(zero), 32'h0);
`endif
    step();
    alu_op = 4'h6; c_in = 1'b1; x = 16'h0005; y = 16'h0007;
    #1 chk("sub_z", 32'(z), 32'hFFFE);
    chk("sub_cout", 32'(c_out), 32'h0);
    step();

    alu_mode = 1'b1; c_in = 1'b1; x = 16'hF0F0; y = 16'hFF00;
    alu_op = 4'hB; #1 chk("log_and", 32'(z), 32'hF000); step();
    alu_op = 4'hE; #1 chk("log_or", 32'(z), 32'hFFF0); step();
    alu_op = 4'h6; #1 chk("log_xor", 32'(z), 32'h0FF0); step();
    alu_op = 4'h0; #1 chk("log_nota", 32'(z), 32'h0F0F); step();
    alu_op = 4'h3; #1 chk("log_zero_z", 32'(z), 32'h0000);
`ifdef ECLAIR_ALU_FLAGS_EN
    chk("log_zero_flag", 32'(zero), 32'h1);
`endif
    step();

    dmx_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] exp_d;
      dmx_sel = 3'(i);
      exp_d = 8'hFF ^ (8'h01 << i);
      #1 chk("dmx_sel", 32'(dmx_out), 32'(exp_d));
      step();
    end
    dmx_en = 1'b0;
    #1 chk("dmx_off", 32'(dmx_out), 32'h00FF);
    step();

    for (int n = 0; n < 500; n++) begin
      reset    = ($urandom_range(0, 15) == 0);
      load     = ($urandom_range(0, 3) == 0);
      inc      = $urandom_range(0, 1) == 1;
      preset   = 16'($urandom);
      alu_mode = $urandom_range(0, 1) == 1;
      alu_op   = 4'($urandom_range(0, 15));
      c_in     = $urandom_range(0, 1) == 1;
      x        = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
      y        = ($urandom_range(0, 7) == 0) ? x : 16'($urandom);
      dmx_sel  = 3'($urandom_range(0, 7));
      dmx_en   = $urandom_range(0, 1) == 1;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
